// File: rtl/mmio_pkg.sv
// Shared MMIO bus definitions: address window, FSM state encodings and
// base addresses of the peripherals living in the 0xFFFFxxxx page.
package mmio_pkg;

    // Upper half-word that marks an address as memory-mapped I/O
    localparam logic [15:0] MMIO_BASE_HI  = 16'hFFFF;

    // Bus master FSM encodings (kept as plain constants for older tools)
    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_ACCESS     = 2'd1;
    localparam logic [1:0]  ST_RESP       = 2'd2;

    // Peripheral base addresses
    localparam logic [31:0] LEDS_BASE     = 32'hFFFF_0080;
    localparam logic [31:0] SWITCHES_BASE = 32'hFFFF_0090;
    localparam logic [31:0] SEG7_BASE     = 32'hFFFF_00A0;
    localparam logic [31:0] UART_BASE     = 32'hFFFF_00C0;

    // True when an address falls inside the MMIO page
    function automatic logic is_mmio_addr(input logic [31:0] addr);
        return (addr[31:16] == MMIO_BASE_HI);
    endfunction

endpackage

// File: rtl/mmio_onehot_sel.sv
// Decodes the per-device claim vector: exactly-one / more-than-one flags,
// the index of the claiming slot and that slot's read data.
module mmio_onehot_sel #(
    parameter int N_DEV = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_DEV-1:0]    i_work,
    input  logic [32*N_DEV-1:0] i_rdata,
    output logic                o_valid,
    output logic                o_multi,
    output logic [IDX_W-1:0]    o_index,
    output logic [31:0]         o_rdata
);
    import mmio_pkg::*;

    localparam logic [N_DEV-1:0] ONE = {{(N_DEV-1){1'b0}}, 1'b1};

    // Claim classification, lowest-set-bit index and read-data mux
    always_comb begin
        o_multi = |(i_work & (i_work - ONE));
        o_valid = (|i_work) & ~o_multi;
        o_index = {IDX_W{1'b0}};
        o_rdata = 32'h0000_0000;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (i_work[i]) begin
                o_index = IDX_W'(i);
            end else begin
                o_index = o_index;
            end
        end
        for (int i = 0; i < N_DEV; i++) begin
            if (o_valid && (o_index == IDX_W'(i))) begin
                o_rdata = i_rdata[32*i +: 32];
            end else begin
                o_rdata = o_rdata;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_master.sv
// Single-outstanding MMIO bus master: latches one CPU load/store, broadcasts
// it to the peripherals, waits for the claiming device's done pulse and acks
// the CPU. Unclaimed, multiply-claimed and timed-out accesses return err=1.
module mmio_bus_master #(
    parameter int N_DEV   = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                cpu_req_read,
    input  logic                cpu_req_write,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_stall,
    output logic                cpu_ack,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_err,
    output logic                mmio_read,
    output logic                mmio_write,
    output logic [31:0]         mmio_addr,
    output logic [31:0]         mmio_write_data,
    input  logic [N_DEV-1:0]    dev_work,
    input  logic [N_DEV-1:0]    dev_done,
    input  logic [32*N_DEV-1:0] dev_rdata
);
    import mmio_pkg::*;

    localparam int             IDX_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_is_read;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [TO_W-1:0]  r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_valid;
    logic             w_multi;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_sel_rdata;
    logic [1:0]       w_state_nx;
    logic             w_finish;
    logic             w_err_nx;
    logic [31:0]      w_rdata_nx;
    logic [TO_W-1:0]  w_cnt_inc;

    mmio_onehot_sel #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_work  (dev_work),
        .i_rdata (dev_rdata),
        .o_valid (w_valid),
        .o_multi (w_multi),
        .o_index (w_idx),
        .o_rdata (w_sel_rdata)
    );

    // Next-state and completion decision; claim errors beat done, done beats timeout
    always_comb begin
        w_state_nx = r_state;
        w_finish   = 1'b0;
        w_err_nx   = 1'b0;
        w_rdata_nx = 32'h0000_0000;
        w_cnt_inc  = r_cnt + TO_ONE;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req_read || cpu_req_write) begin
                    w_state_nx = ST_ACCESS;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_multi || !(|dev_work)) begin
                    w_state_nx = ST_RESP;
                    w_finish   = 1'b1;
                    w_err_nx   = 1'b1;
                end else if (w_valid && dev_done[w_idx]) begin
                    w_state_nx = ST_RESP;
                    w_finish   = 1'b1;
                    w_rdata_nx = r_is_read ? w_sel_rdata : 32'h0000_0000;
                end else if (w_cnt_inc == TO_LIM) begin
                    w_state_nx = ST_RESP;
                    w_finish   = 1'b1;
                    w_err_nx   = 1'b1;
                end else begin
                    w_state_nx = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and access-cycle counter (cleared outside ACCESS)
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {TO_W{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= (r_state == ST_ACCESS) ? w_cnt_inc : {TO_W{1'b0}};
        end
    end

    // Request latches; only loaded on acceptance so the bus lines never toggle idle
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_is_read <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
        end else if ((r_state == ST_IDLE) && (w_state_nx == ST_ACCESS)) begin
            r_is_read <= cpu_req_read;
            r_addr    <= cpu_addr;
            r_wdata   <= cpu_wdata;
        end
    end

    // Response data/error: captured on completion, visible only during the ack cycle
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else if (w_finish) begin
            r_rdata <= w_rdata_nx;
            r_err   <= w_err_nx;
        end else if (r_state == ST_RESP) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end
    end

    assign cpu_ack         = (r_state == ST_RESP);
    assign cpu_stall       = (cpu_req_read | cpu_req_write) & ~cpu_ack;
    assign cpu_rdata       = r_rdata;
    assign cpu_err         = r_err;
    assign mmio_read       = (r_state == ST_ACCESS) &  r_is_read;
    assign mmio_write      = (r_state == ST_ACCESS) & ~r_is_read;
    assign mmio_addr       = r_addr;
    assign mmio_write_data = r_wdata;

endmodule
